// File: rtl/cpu_pkg.sv
// Shared definitions for the S-Machine CPU.
// Contents:
//   ADDR_W / INST_W - program counter and instruction word widths.
//   fetch_state_t   - fetch FSM state encoding.
//   HALT_WORD_DEF   - default instruction encoding that stops fetching.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;

  localparam logic [INST_W-1:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, reset - clock and asynchronous active-high reset (pc <= RESET_PC)
//   load       - load target into pc; takes priority over inc
//   inc        - advance pc by one, wrapping modulo 256
//   target     - value loaded when load is high
//   pc         - current program counter
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 8'd1;  // carry out is dropped on purpose
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC into the combinational instruction
// memory, captures the returned word into ir and hands it to the decoder
// over a valid/ready handshake. Execute redirects override everything;
// a HALT_WORD stops fetching until a redirect or reset.
// Ports:
//   clk, reset       - clock and asynchronous active-high reset
//   mem_addr/mem_data - instruction memory address out / word in
//   ir, ir_pc        - captured instruction and its fetch address
//   ir_valid/ir_ready - handshake to the decoder
//   redirect_valid/redirect_target - control-flow change from execute
//   halted           - high while in HALTED
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | one bubble cycle after reset, no fetch
// FETCH  | fetch one word per cycle whenever ir is free or being taken
// HALTED | halt word seen; pc frozen, ir may still drain
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter logic [INST_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_data,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              fire;
  logic              is_halt;

  assign fire     = (state == FETCH) && (!ir_valid || ir_ready) && !redirect_valid;
  assign is_halt  = (mem_data == HALT_WORD);
  assign mem_addr = pc;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (redirect_valid),
    .inc    (fire && !is_halt),
    .target (redirect_target),
    .pc     (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      // Flush wins even over a same-cycle accept from the decoder.
      state    <= FETCH;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      // Default accept; overridden below when a fetch refills ir.
      if (ir_valid && ir_ready) begin
        ir_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (fire) begin
            ir       <= mem_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (is_halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        halted;

  logic [15:0] mem [256];
  int passed;
  int total;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .ir              (ir),
    .ir_pc           (ir_pc),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted)
  );

  assign mem_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word at address a is 0x1000 + a + 1; never equals the halt word.
  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i) + 16'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 8'h00;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ir_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 8'h00;
    step();
    total++; if (ir_valid !== 1'b0) $display("FAIL reset_ir_valid: got %b expected 0", ir_valid); else passed++;
    total++; if (ir !== 16'h0000) $display("FAIL reset_ir: got %h expected 0000", ir); else passed++;
    total++; if (ir_pc !== 8'h00) $display("FAIL reset_ir_pc: got %h expected 00", ir_pc); else passed++;
    total++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_straight_line();
    logic [15:0] exp_ir [4];
    exp_ir[0] = 16'h1001; exp_ir[1] = 16'h1002; exp_ir[2] = 16'h1003; exp_ir[3] = 16'h1004;
    ir_ready = 1'b1;
    do_reset();
    step();  // edge 1: IDLE -> FETCH
    total++; if (ir_valid !== 1'b0) $display("FAIL idle_bubble_valid: got %b expected 0", ir_valid); else passed++;
    total++; if (mem_addr !== 8'h00) $display("FAIL idle_bubble_addr: got %h expected 00", mem_addr); else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (ir_valid !== 1'b1) $display("FAIL line_valid[%0d]: got %b expected 1", i, ir_valid); else passed++;
      total++; if (ir !== exp_ir[i]) $display("FAIL line_ir[%0d]: got %h expected %h", i, ir, exp_ir[i]); else passed++;
      total++; if (ir_pc !== 8'(i)) $display("FAIL line_ir_pc[%0d]: got %h expected %h", i, ir_pc, 8'(i)); else passed++;
    end
  endtask

  task automatic test_stall();
    ir_ready = 1'b1;
    do_reset();
    step(); step(); step();  // ir = 1002 after edge 3
    total++; if (ir !== 16'h1002) $display("FAIL stall_pre_ir: got %h expected 1002", ir); else passed++;
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (mem_addr !== 8'h02) $display("FAIL stall_addr[%0d]: got %h expected 02", i, mem_addr); else passed++;
      total++; if (ir !== 16'h1002) $display("FAIL stall_ir[%0d]: got %h expected 1002", i, ir); else passed++;
      total++; if (ir_pc !== 8'h01) $display("FAIL stall_ir_pc[%0d]: got %h expected 01", i, ir_pc); else passed++;
      total++; if (ir_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b expected 1", i, ir_valid); else passed++;
    end
    ir_ready = 1'b1;
    step();
    total++; if (ir !== 16'h1003) $display("FAIL stall_release_ir: got %h expected 1003", ir); else passed++;
    total++; if (ir_pc !== 8'h02) $display("FAIL stall_release_ir_pc: got %h expected 02", ir_pc); else passed++;
  endtask

  task automatic test_redirect();
    ir_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) step();  // mem_addr = 5
    total++; if (mem_addr !== 8'h05) $display("FAIL redir_pre_addr: got %h expected 05", mem_addr); else passed++;
    redirect_valid = 1'b1;
    redirect_target = 8'h40;
    step();
    redirect_valid = 1'b0;
    total++; if (ir_valid !== 1'b0) $display("FAIL redir_flush_valid: got %b expected 0", ir_valid); else passed++;
    total++; if (mem_addr !== 8'h40) $display("FAIL redir_addr: got %h expected 40", mem_addr); else passed++;
    step();
    total++; if (ir_valid !== 1'b1) $display("FAIL redir_refill_valid: got %b expected 1", ir_valid); else passed++;
    total++; if (ir !== 16'h1041) $display("FAIL redir_ir: got %h expected 1041", ir); else passed++;
    total++; if (ir_pc !== 8'h40) $display("FAIL redir_ir_pc: got %h expected 40", ir_pc); else passed++;
  endtask

  task automatic test_halt();
    ir_ready = 1'b1;
    mem[3] = 16'hFFFF;
    do_reset();
    for (int i = 0; i < 5; i++) step();  // ir = mem[3]
    total++; if (ir !== 16'hFFFF) $display("FAIL halt_ir: got %h expected ffff", ir); else passed++;
    total++; if (ir_pc !== 8'h03) $display("FAIL halt_ir_pc: got %h expected 03", ir_pc); else passed++;
    total++; if (halted !== 1'b1) $display("FAIL halt_flag: got %b expected 1", halted); else passed++;
    total++; if (mem_addr !== 8'h03) $display("FAIL halt_addr: got %h expected 03", mem_addr); else passed++;
    step(); step();
    total++; if (mem_addr !== 8'h03) $display("FAIL halt_addr_frozen: got %h expected 03", mem_addr); else passed++;
    total++; if (ir_valid !== 1'b0) $display("FAIL halt_drain_valid: got %b expected 0", ir_valid); else passed++;
    total++; if (halted !== 1'b1) $display("FAIL halt_flag_held: got %b expected 1", halted); else passed++;
    redirect_valid = 1'b1;
    redirect_target = 8'h00;
    step();
    redirect_valid = 1'b0;
    total++; if (halted !== 1'b0) $display("FAIL halt_exit_flag: got %b expected 0", halted); else passed++;
    total++; if (ir_valid !== 1'b0) $display("FAIL halt_exit_bubble: got %b expected 0", ir_valid); else passed++;
    step();
    total++; if (ir !== 16'h1001) $display("FAIL halt_exit_ir: got %h expected 1001", ir); else passed++;
    total++; if (ir_pc !== 8'h00) $display("FAIL halt_exit_ir_pc: got %h expected 00", ir_pc); else passed++;
    mem[3] = 16'h1004;
  endtask

  task automatic test_redirect_vs_halt();
    ir_ready = 1'b1;
    mem[3] = 16'hFFFF;
    do_reset();
    for (int i = 0; i < 4; i++) step();  // mem_addr = 3, halt word on mem_data
    total++; if (mem_data !== 16'hFFFF) $display("FAIL rvh_pre_data: got %h expected ffff", mem_data); else passed++;
    redirect_valid = 1'b1;
    redirect_target = 8'h10;
    step();
    redirect_valid = 1'b0;
    total++; if (halted !== 1'b0) $display("FAIL rvh_halted: got %b expected 0", halted); else passed++;
    total++; if (mem_addr !== 8'h10) $display("FAIL rvh_addr: got %h expected 10", mem_addr); else passed++;
    step();
    total++; if (ir !== 16'h1011) $display("FAIL rvh_ir: got %h expected 1011", ir); else passed++;
    mem[3] = 16'h1004;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
    ir_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 8'hFE;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (ir_pc !== exp_pc[i]) $display("FAIL wrap_ir_pc[%0d]: got %h expected %h", i, ir_pc, exp_pc[i]); else passed++;
      total++; if (ir !== 16'h1000 + 16'(exp_pc[i]) + 16'd1) $display("FAIL wrap_ir[%0d]: got %h expected %h", i, ir, 16'h1000 + 16'(exp_pc[i]) + 16'd1); else passed++;
    end
  endtask

  task automatic test_async_reset();
    ir_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    total++; if (ir_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", ir_valid); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (ir_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", ir_valid); else passed++;
    total++; if (ir !== 16'h0000) $display("FAIL areset_ir: got %h expected 0000", ir); else passed++;
    total++; if (mem_addr !== 8'h00) $display("FAIL areset_addr: got %h expected 00", mem_addr); else passed++;
    #1;
    reset = 1'b0;
    step();
    total++; if (ir_valid !== 1'b0) $display("FAIL areset_idle_bubble: got %b expected 0", ir_valid); else passed++;
    step();
    total++; if (ir !== 16'h1001) $display("FAIL areset_first_ir: got %h expected 1001", ir); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 8'h00;
    load_mem();
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_halt();
    test_redirect_vs_halt();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
